// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle processor control block.
//   - state_t     : controller FSM states
//   - OP_*        : opcode values carried in IR[15:12]
//   - BSEL_*      : adder B-operand mux encodings (add_b_sel)
//   - PCSRC_*     : PC load source encodings (pc_src); value 2 is reserved
//   - op_class_t  : per-opcode classification produced by mc_decode
//   - PC_STEP_DEFAULT : PC increment per fetched instruction (bit-addressed PC)
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_BRANCH = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_LW   = 4'd2;
    localparam logic [3:0] OP_SW   = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd4;
    localparam logic [3:0] OP_JMP  = 4'd5;
    localparam logic [3:0] OP_NOP  = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [1:0] BSEL_STEP = 2'd0;  // PC_STEP constant
    localparam logic [1:0] BSEL_RT   = 2'd1;  // rt
    localparam logic [1:0] BSEL_NRT  = 2'd2;  // ~rt (with cin=1 gives -rt)
    localparam logic [1:0] BSEL_IMM  = 2'd3;  // sign-extended IR[7:0]

    localparam logic [1:0] PCSRC_ADD = 2'd0;  // adder result
    localparam logic [1:0] PCSRC_JMP = 2'd1;  // IR[11:0] zero-extended

    localparam int PC_STEP_DEFAULT = 16;

    typedef struct packed {
        logic needs_exec;
        logic needs_mem;
        logic is_store;
        logic is_load;
        logic is_branch;
        logic is_jump;
        logic is_halt;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode classifier.
// Ports:
//   opcode_i [3:0]  instruction opcode (IR[15:12] or its registered copy)
//   class_o         op_class_t flags describing which phases the opcode needs
// NOP sets no flag at all; every value outside the defined set is illegal.
module mc_decode
    import mc_pkg::*;
(
    input  logic [3:0] opcode_i,
    output op_class_t  class_o
);

    always_comb begin
        class_o = '0;
        case (opcode_i)
            OP_ADD, OP_SUB: begin
                class_o.needs_exec = 1'b1;
            end
            OP_LW: begin
                class_o.needs_exec = 1'b1;
                class_o.needs_mem  = 1'b1;
                class_o.is_load    = 1'b1;
            end
            OP_SW: begin
                class_o.needs_exec = 1'b1;
                class_o.needs_mem  = 1'b1;
                class_o.is_store   = 1'b1;
            end
            OP_BEQ: begin
                class_o.needs_exec = 1'b1;
                class_o.is_branch  = 1'b1;
            end
            OP_JMP: begin
                class_o.is_jump = 1'b1;
            end
            OP_NOP: begin
                class_o = '0;
            end
            OP_HALT: begin
                class_o.is_halt = 1'b1;
            end
            default: begin
                class_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the 16-bit multicycle processor.
// Sequences FETCH -> DECODE -> EXEC -> MEM -> WB (plus BRANCH and HALT),
// time-shares the single adder and drives the unified memory handshake.
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   opcode [3:0]      IR[15:12], valid from DECODE onward
//   zero              adder result == 0, used in EXEC for BEQ
//   mem_ready         memory completes the current request this cycle
//   mem_req/mem_we    memory request / write qualifier
//   mem_addr_sel      0 = PC, 1 = adder result register
//   ir_we, pc_we      IR and PC load enables
//   pc_src [1:0]      0 = adder result, 1 = jump target
//   add_a_sel         0 = PC, 1 = rs
//   add_b_sel [1:0]   0 = PC_STEP, 1 = rt, 2 = ~rt, 3 = sext(IR[7:0])
//   add_cin           adder carry-in
//   res_we            latch adder result/carry into the result register
//   reg_we, wb_sel    register-file write, 0 = result reg / 1 = MDR
//   halted            sticky after HALT until rst
//   illegal_op        one-cycle pulse on an undefined opcode
//   pc_step_o [15:0]  the PC_STEP constant the datapath feeds when add_b_sel=0,
//                     so the increment is defined in one place
//   dbg_state_o       current FSM state
//
// Memory handshake: mem_req is a valid-style request that, once raised in
// FETCH or MEM, stays high with stable mem_addr_sel/mem_we until the cycle
// in which mem_ready is high; that cycle completes the transfer. mem_ready
// seen while mem_req is low carries no meaning and is ignored. Reset
// abandons an outstanding request in the same cycle.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int PC_STEP = PC_STEP_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        add_a_sel,
    output logic [1:0]  add_b_sel,
    output logic        add_cin,
    output logic        res_we,
    output logic        reg_we,
    output logic        wb_sel,
    output logic        halted,
    output logic        illegal_op,
    output logic [15:0] pc_step_o,
    output state_t      dbg_state_o
);

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [3:0] cur_op;
    op_class_t  cls;

    // In DECODE the live opcode is classified and captured; afterwards the
    // captured copy is used, so later changes on the opcode input are ignored.
    assign cur_op = (state_q == ST_DECODE) ? opcode : op_q;

    mc_decode u_decode (
        .opcode_i (cur_op),
        .class_o  (cls)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            op_q    <= OP_NOP;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PCSRC_ADD;
        add_a_sel    = 1'b0;
        add_b_sel    = BSEL_STEP;
        add_cin      = 1'b0;
        res_we       = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 1'b0;
        halted       = 1'b0;
        illegal_op   = 1'b0;

        // Reset gates every output combinationally: an in-flight request is
        // dropped and a coincident mem_ready produces no load enables.
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b0;
                    add_a_sel    = 1'b0;
                    add_b_sel    = BSEL_STEP;
                    add_cin      = 1'b0;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        pc_src  = PCSRC_ADD;
                        state_d = ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    op_d = opcode;
                    if (cls.needs_exec) begin
                        state_d = ST_EXEC;
                    end else if (cls.is_jump) begin
                        pc_we   = 1'b1;
                        pc_src  = PCSRC_JMP;
                        state_d = ST_FETCH;
                    end else if (cls.is_halt) begin
                        state_d = ST_HALT;
                    end else if (cls.illegal) begin
                        illegal_op = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end

                ST_EXEC: begin
                    add_a_sel = 1'b1;
                    res_we    = 1'b1;
                    if (cls.is_branch) begin
                        // rs + ~rt + 1 = rs - rt; zero flags equality
                        add_b_sel = BSEL_NRT;
                        add_cin   = 1'b1;
                        state_d   = zero ? ST_BRANCH : ST_FETCH;
                    end else if (cls.needs_mem) begin
                        add_b_sel = BSEL_IMM;
                        state_d   = ST_MEM;
                    end else if (op_q == OP_SUB) begin
                        add_b_sel = BSEL_NRT;
                        add_cin   = 1'b1;
                        state_d   = ST_WB;
                    end else begin
                        add_b_sel = BSEL_RT;
                        state_d   = ST_WB;
                    end
                end

                ST_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = cls.is_store;
                    if (mem_ready) begin
                        state_d = cls.is_load ? ST_WB : ST_FETCH;
                    end
                end

                ST_WB: begin
                    reg_we  = 1'b1;
                    wb_sel  = cls.is_load;
                    state_d = ST_FETCH;
                end

                ST_BRANCH: begin
                    // PC already points past the BEQ; offset is in bit units
                    add_a_sel = 1'b0;
                    add_b_sel = BSEL_IMM;
                    add_cin   = 1'b0;
                    pc_we     = 1'b1;
                    pc_src    = PCSRC_ADD;
                    state_d   = ST_FETCH;
                end

                ST_HALT: begin
                    halted  = 1'b1;
                    state_d = ST_HALT;
                end

                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    assign pc_step_o   = 16'(PC_STEP);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl. The whole stimulus stream is generated up front
// from an instruction-level model: each instruction expands into the list of
// per-cycle control words the processor should see, together with the
// inputs to drive in each of those cycles. A driver applies the inputs one
// cycle at a time; a separate monitor pops the expected control word and
// compares it against the DUT outputs at the falling edge.
module tb_multicycle_ctrl;

    // opcode values from the instruction set
    localparam logic [3:0] I_ADD  = 4'd0;
    localparam logic [3:0] I_SUB  = 4'd1;
    localparam logic [3:0] I_LW   = 4'd2;
    localparam logic [3:0] I_SW   = 4'd3;
    localparam logic [3:0] I_BEQ  = 4'd4;
    localparam logic [3:0] I_JMP  = 4'd5;
    localparam logic [3:0] I_NOP  = 4'd6;
    localparam logic [3:0] I_HALT = 4'd15;

    // bit positions inside a packed control word
    localparam int B_REQ   = 15;
    localparam int B_WE    = 14;
    localparam int B_ASEL  = 13;
    localparam int B_IRWE  = 12;
    localparam int B_PCWE  = 11;
    localparam int B_PCS   = 9;   // [10:9]
    localparam int B_A     = 8;
    localparam int B_B     = 6;   // [7:6]
    localparam int B_CIN   = 5;
    localparam int B_RESWE = 4;
    localparam int B_REGWE = 3;
    localparam int B_WB    = 2;
    localparam int B_HLT   = 1;
    localparam int B_ILL   = 0;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  opcode = 4'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
    logic [1:0]  pc_src, add_b_sel;
    logic        add_a_sel, add_cin, res_we, reg_we, wb_sel, halted, illegal_op;
    logic [15:0] pc_step;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .add_a_sel    (add_a_sel),
        .add_b_sel    (add_b_sel),
        .add_cin      (add_cin),
        .res_we       (res_we),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .halted       (halted),
        .illegal_op   (illegal_op),
        .pc_step_o    (pc_step),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- queues and counters ----------------
    typedef struct packed {
        logic       r;
        logic       rdy;
        logic       z;
        logic [3:0] op;
    } drv_t;

    drv_t        drv_q[$];
    logic [15:0] exp_q[$];
    string       tag_q[$];
    int          applied = 0;
    int          checked = 0;
    int          total   = 0;
    int          bad     = 0;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic push(input logic r, input logic rdy, input logic z,
                        input logic [3:0] op, input logic [15:0] e, input string tag);
        drv_t d;
        d.r   = r;
        d.rdy = rdy;
        d.z   = z;
        d.op  = op;
        drv_q.push_back(d);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // ---------------- reference model (instruction level) ----------------
    task automatic reset_cycle(input logic rdy);
        push(1'b1, rdy, rbit(), rop(), 16'h0000, "reset");
    endtask

    // fetch with fw wait cycles, then the completing cycle
    task automatic fetch(input int fw);
        logic [15:0] e;
        for (int i = 0; i < fw; i++) begin
            e = '0;
            e[B_REQ] = 1'b1;
            push(1'b0, 1'b0, rbit(), rop(), e, "fetch_wait");
        end
        e = '0;
        e[B_REQ]  = 1'b1;
        e[B_IRWE] = 1'b1;
        e[B_PCWE] = 1'b1;
        push(1'b0, 1'b1, rbit(), rop(), e, "fetch_done");
    endtask

    task automatic mem_cycle(input logic store, input logic rdy, input string tag);
        logic [15:0] e;
        e = '0;
        e[B_REQ]  = 1'b1;
        e[B_ASEL] = 1'b1;
        e[B_WE]   = store;
        push(1'b0, rdy, rbit(), rop(), e, tag);
    endtask

    task automatic issue(input logic [3:0] op, input logic z, input int fw, input int mw);
        logic [15:0] e;
        logic        uses_alu;
        fetch(fw);
        // decode
        e = '0;
        if (op == I_JMP) begin
            e[B_PCWE] = 1'b1;
            e[B_PCS +: 2] = 2'd1;
        end else if (op >= 4'd7 && op <= 4'd14) begin
            e[B_ILL] = 1'b1;
        end
        push(1'b0, rbit(), rbit(), op, e, "decode");
        uses_alu = (op == I_ADD || op == I_SUB || op == I_LW || op == I_SW || op == I_BEQ);
        if (uses_alu) begin
            // execute: rs + rt, rs - rt, or rs + imm
            e = '0;
            e[B_A] = 1'b1;
            e[B_RESWE] = 1'b1;
            if (op == I_ADD) begin
                e[B_B +: 2] = 2'd1;
            end else if (op == I_SUB || op == I_BEQ) begin
                e[B_B +: 2] = 2'd2;
                e[B_CIN] = 1'b1;
            end else begin
                e[B_B +: 2] = 2'd3;
            end
            push(1'b0, rbit(), z, rop(), e, "exec");
            if (op == I_LW || op == I_SW) begin
                for (int i = 0; i < mw; i++) mem_cycle(op == I_SW, 1'b0, "mem_wait");
                mem_cycle(op == I_SW, 1'b1, "mem_done");
            end
            if (op == I_ADD || op == I_SUB || op == I_LW) begin
                e = '0;
                e[B_REGWE] = 1'b1;
                e[B_WB] = (op == I_LW);
                push(1'b0, rbit(), rbit(), rop(), e, "writeback");
            end
            if (op == I_BEQ && z) begin
                e = '0;
                e[B_PCWE] = 1'b1;
                e[B_B +: 2] = 2'd3;
                push(1'b0, rbit(), rbit(), rop(), e, "branch");
            end
        end
    endtask

    // HALT followed by n halted cycles, then a reset that clears it
    task automatic halt_seq(input int fw, input int n);
        logic [15:0] e;
        fetch(fw);
        push(1'b0, rbit(), rbit(), I_HALT, 16'h0000, "decode_halt");
        e = '0;
        e[B_HLT] = 1'b1;
        for (int i = 0; i < n; i++) push(1'b0, rbit(), rbit(), rop(), e, "halted");
        reset_cycle(rbit());
    endtask

    // SW whose memory phase is cut short by reset after w wait cycles
    task automatic sw_reset(input int w, input logic rdy_at_rst);
        logic [15:0] e;
        fetch(0);
        push(1'b0, rbit(), rbit(), I_SW, 16'h0000, "decode_sw");
        e = '0;
        e[B_A] = 1'b1;
        e[B_RESWE] = 1'b1;
        e[B_B +: 2] = 2'd3;
        push(1'b0, rbit(), rbit(), rop(), e, "exec_sw");
        for (int i = 0; i < w; i++) mem_cycle(1'b1, 1'b0, "mem_wait_sw");
        push(1'b1, rdy_at_rst, rbit(), rop(), 16'h0000, "reset_in_mem");
    endtask

    // ---------------- stimulus build + driver ----------------
    initial begin : driver
        drv_t d;
        logic [3:0] op;
        int r;

        reset_cycle(1'b0);
        reset_cycle(1'b1);            // mem_ready during reset: no enables
        issue(I_ADD, 1'b0, 0, 0);     // 4 cycles
        issue(I_LW,  1'b0, 0, 3);     // 8 cycles with 3 memory waits
        issue(I_BEQ, 1'b1, 0, 0);     // taken
        issue(I_BEQ, 1'b0, 0, 0);     // not taken
        issue(I_JMP, 1'b0, 0, 0);
        issue(4'd9,  1'b0, 0, 0);     // illegal
        issue(I_SUB, 1'b1, 2, 0);
        issue(I_SW,  1'b0, 1, 2);
        issue(I_NOP, 1'b0, 0, 0);
        sw_reset(1, 1'b0);
        sw_reset(2, 1'b1);
        halt_seq(0, 20);
        issue(I_NOP, 1'b0, 0, 0);     // fetch resumes after reset
        issue(4'd14, 1'b0, 1, 0);
        issue(4'd7,  1'b0, 0, 0);

        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                halt_seq($urandom_range(0, 2), $urandom_range(1, 4));
            end else if (r == 1) begin
                sw_reset($urandom_range(0, 2), rbit());
            end else begin
                op = 4'($urandom_range(0, 14));
                issue(op, rbit(), $urandom_range(0, 2), $urandom_range(0, 3));
            end
        end

        while (drv_q.size() > 0) begin
            @(posedge clk);
            #1;
            d = drv_q.pop_front();
            rst       = d.r;
            mem_ready = d.rdy;
            zero      = d.z;
            opcode    = d.op;
            applied++;
        end

        for (int i = 0; i < 10 && checked < applied; i++) @(posedge clk);
        if (checked < applied) begin
            bad++;
            $display("FAIL drain: checked=%0d required=%0d", checked, applied);
        end

        total++;
        if (pc_step !== 16'd16) begin
            bad++;
            $display("FAIL pc_step: got=%0d want=16", pc_step);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [15:0] exp_w, act_w;
        string       tag;
        forever begin
            @(negedge clk);
            if (applied > checked && exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                tag   = tag_q.pop_front();
                act_w = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
                         add_a_sel, add_b_sel, add_cin, res_we, reg_we,
                         wb_sel, halted, illegal_op};
                total++;
                if (act_w !== exp_w) begin
                    bad++;
                    $display("FAIL %s cycle=%0d got=%h want=%h (req,we,asel,irwe,pcwe,pcsrc2,a,b2,cin,reswe,regwe,wb,hlt,ill)",
                             tag, checked, act_w, exp_w);
                end
                checked++;
            end
        end
    end

endmodule
